// File: rtl/fetch_queue.sv
// Fetch front end: owns the fetch PC, reads imem combinationally and
// buffers {pc, instr} pairs for decode over a valid/ready handshake.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];
  logic          deq;
  logic          enq;

  assign imem_addr = fetch_pc;
  assign out_valid = (count != '0);
  assign full      = (count == DEPTH_C);
  assign out_pc    = mem_pc[head];
  assign out_instr = mem_instr[head];

  // A full queue may still accept a word when the head leaves this cycle.
  assign deq = out_valid & out_ready & ~redirect_valid;
  assign enq = ~redirect_valid & ((count < DEPTH_C) | deq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      if (enq) begin
        tail     <= tail + AW'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (deq) begin
        head <= head + AW'(1);
      end
      unique case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_pc[tail]    <= fetch_pc;
      mem_instr[tail] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based model,
// plus directed scenarios with hand-computed expectations.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        full;

  int passed = 0;
  int total  = 0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_instr(out_instr),
    .full(full)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'h100 + {2'b00, a[31:2]};
  endfunction

  assign imem_rdata = imem(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: a queue of fetched words and the next fetch address.
  logic [63:0] mq[$];
  logic [31:0] mpc;

  always @(negedge rst_n) begin
    mq.delete();
    mpc = RPC;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (redirect_valid) begin
        mq.delete();
        mpc = {redirect_pc[31:2], 2'b00};
      end else begin
        bit d, e;
        d = (mq.size() != 0) && out_ready;
        e = (mq.size() < DEPTH) || d;
        if (d) void'(mq.pop_front());
        if (e) begin
          mq.push_back({mpc, imem(mpc)});
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("imem_addr", imem_addr, mpc);
    if (mq.size() != 0) begin
      chk("out_pc", out_pc, mq[0][63:32]);
      chk("out_instr", out_instr, mq[0][31:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    mpc            = RPC;
    repeat (3) tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", imem_addr, RPC);

    // Stream from reset with no gaps.
    rst_n = 1'b1;
    chk("pre_valid", 32'(out_valid), 32'd0);
    tick();
    chk("s1_valid", 32'(out_valid), 32'd1);
    chk("s1_pc0", out_pc, 32'h0);
    chk("s1_in0", out_instr, 32'h100);
    tick();
    chk("s1_pc1", out_pc, 32'h4);
    chk("s1_in1", out_instr, 32'h101);
    tick();
    chk("s1_pc2", out_pc, 32'h8);

    // Fill while stalled, then drain at full rate.
    out_ready = 1'b0;
    redir(32'h0);
    repeat (4) tick();
    chk("s2_full4", 32'(full), 32'd1);
    repeat (6) tick();
    chk("s2_addr", imem_addr, 32'h10);
    chk("s2_head", out_pc, 32'h0);
    out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("s3_pc", out_pc, 32'(4 * i));
      chk("s3_full", 32'(full), 32'd1);
    end

    // Redirect with entries queued; head handshake is not a transfer.
    out_ready = 1'b0;
    redir(32'h200);
    repeat (3) tick();
    out_ready = 1'b1;
    redir(32'h40);
    chk("s4_valid", 32'(out_valid), 32'd0);
    chk("s4_addr", imem_addr, 32'h40);
    tick();
    chk("s4_pc", out_pc, 32'h40);
    chk("s4_in", out_instr, 32'h110);

    // Unaligned target and back-to-back redirects.
    redir(32'h43);
    chk("s5_align", imem_addr, 32'h40);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    chk("s5_addr", imem_addr, 32'h80);
    tick();
    chk("s5_pc", out_pc, 32'h80);

    // Fetch PC wraps silently past the top of the address space.
    redir(32'hFFFF_FFF8);
    repeat (3) tick();
    chk("wrap_pc", out_pc, 32'h0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom();
      tick();
    end
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    repeat (3) tick();

    // Asynchronous reset pulse between edges.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #0.5;
    chk("s6_valid", 32'(out_valid), 32'd0);
    chk("s6_full", 32'(full), 32'd0);
    chk("s6_addr", imem_addr, RPC);
    #0.5;
    rst_n = 1'b1;
    tick();
    chk("s6_pc", out_pc, RPC);
    chk("s6_in", out_instr, 32'h100);
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
